// File: rtl/mp_cmpl_pkg.sv
// Shared widths and return-word field positions for the completion path.
package mp_cmpl_pkg;

  localparam int PID_WIDTH    = 9;
  localparam int CODE_WIDTH   = 32;
  localparam int RETURN_WIDTH = PID_WIDTH + CODE_WIDTH;

  localparam int RET_PID_MSB  = 40;
  localparam int RET_PID_LSB  = 32;
  localparam int RET_CODE_MSB = 31;

  // Builds the completion-writer word: PID in the upper bits, code below.
  function automatic logic [RETURN_WIDTH-1:0] pack_return(
    input logic [PID_WIDTH-1:0]  pid,
    input logic [CODE_WIDTH-1:0] code
  );
    return {pid, code};
  endfunction

endpackage

// File: rtl/mp_rr_arbiter.sv
// Combinational round-robin find-first: the request vector is doubled and the
// lanes below rr_ptr are masked, so the first set bit is the wrapped winner.
module mp_rr_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [2*NUM_REQ-1:0] dbl_req;
  logic [2*NUM_REQ-1:0] masked_req;
  logic                 found;

  assign dbl_req = {req, req};

  always_comb begin
    masked_req = '0;
    for (int p = 0; p < 2*NUM_REQ; p++) begin
      masked_req[p] = dbl_req[p] && (p >= int'(rr_ptr));
    end
  end

  // Any requester is present somewhere in [rr_ptr, rr_ptr+NUM_REQ-1] of the doubled vector.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int p = 0; p < 2*NUM_REQ; p++) begin
      if (en && !found && masked_req[p]) begin
        found            = 1'b1;
        grant[p % NUM_REQ] = 1'b1;
        grant_idx        = IDX_W'(p % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mp_completion_arbiter.sv
// Holds one pending completion per engine and round-robin pushes them into
// the completion writer, one {pid, code} word per cycle at most.
module mp_completion_arbiter
  import mp_cmpl_pkg::*;
#(
  parameter int NUM_REQ    = 8,
  parameter int PID_WIDTH  = mp_cmpl_pkg::PID_WIDTH,
  parameter int CODE_WIDTH = mp_cmpl_pkg::CODE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*PID_WIDTH-1:0]    req_pid_i,
  input  logic [NUM_REQ*CODE_WIDTH-1:0]   req_code_i,
  input  logic                            arb_en_i,
  input  logic                            complete_ready_i,
  output logic                            complete_push_o,
  output logic [PID_WIDTH+CODE_WIDTH-1:0] return_data_o,
  output logic [NUM_REQ-1:0]              pending_o,
  output logic [31:0]                     cmpl_count_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    hold_valid;
  logic [PID_WIDTH-1:0]  hold_pid  [NUM_REQ];
  logic [CODE_WIDTH-1:0] hold_code [NUM_REQ];
  logic [IDX_W-1:0]      rr_ptr;
  logic [31:0]           cmpl_cnt;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    accept;
  logic                  grant_en;

  // Handshake: an engine transfers on a cycle where req_valid_i[i] & req_ready_o[i];
  // valid must not depend on ready. The writer side has no valid/ready pair of its
  // own: complete_push_o is only ever raised while complete_ready_i is high.
  assign grant_en    = arb_en_i & complete_ready_i;
  assign req_ready_o = ~hold_valid | grant;
  assign accept      = req_valid_i & req_ready_o;

  mp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (hold_valid),
    .rr_ptr    (rr_ptr),
    .en        (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign complete_push_o = |grant;
  assign pending_o       = hold_valid;
  assign cmpl_count_o    = cmpl_cnt;

  // One-hot AND-OR mux, so the output is all zeros whenever nothing is granted.
  always_comb begin
    return_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        return_data_o = return_data_o | {hold_pid[i], hold_code[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          hold_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Payload registers only load on accept; their contents are meaningless while
  // the matching hold_valid bit is clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_pid[i]  <= '0;
        hold_code[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          hold_pid[i]  <= req_pid_i[i*PID_WIDTH +: PID_WIDTH];
          hold_code[i] <= req_code_i[i*CODE_WIDTH +: CODE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      cmpl_cnt <= '0;
    end else if (complete_push_o) begin
      rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      cmpl_cnt <= cmpl_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mp_completion_arbiter.sv
// Directed table-driven bench for mp_completion_arbiter, plus hand-written
// sequences for streaming, counter wrap and mid-operation reset.
module tb_mp_completion_arbiter;

  localparam int N  = 8;
  localparam int PW = 9;
  localparam int CW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*PW-1:0] req_pid_i;
  logic [N*CW-1:0] req_code_i;
  logic            arb_en_i;
  logic            complete_ready_i;
  logic            complete_push_o;
  logic [PW+CW-1:0] return_data_o;
  logic [N-1:0]    pending_o;
  logic [31:0]     cmpl_count_o;

  int total;
  int bad;

  mp_completion_arbiter #(
    .NUM_REQ    (N),
    .PID_WIDTH  (PW),
    .CODE_WIDTH (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_pid_i        (req_pid_i),
    .req_code_i       (req_code_i),
    .arb_en_i         (arb_en_i),
    .complete_ready_i (complete_ready_i),
    .complete_push_o  (complete_push_o),
    .return_data_o    (return_data_o),
    .pending_o        (pending_o),
    .cmpl_count_o     (cmpl_count_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  valid;
    logic [8:0]  pid_base;
    logic [31:0] code_base;
    logic        rdy;
    logic        en;
    logic        push;
    logic [8:0]  pid;
    logic [31:0] code;
    logic [7:0]  rr;
    logic [7:0]  pend;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(
    input logic [7:0] valid, input logic [8:0] pb, input logic [31:0] cb,
    input logic rdy, input logic en, input logic push,
    input logic [8:0] pid, input logic [31:0] code,
    input logic [7:0] rr, input logic [7:0] pend, input logic [31:0] cnt
  );
    vec_t v;
    v.valid = valid; v.pid_base = pb; v.code_base = cb; v.rdy = rdy; v.en = en;
    v.push = push; v.pid = pid; v.code = code; v.rr = rr; v.pend = pend; v.cnt = cnt;
    return v;
  endfunction

  // Driver: engine i presents pid_base+i and code_base+i.
  task automatic drive(input logic [7:0] valid, input logic [8:0] pb, input logic [31:0] cb,
                       input logic rdy, input logic en);
    req_valid_i      = valid;
    arb_en_i         = en;
    complete_ready_i = rdy;
    for (int i = 0; i < N; i++) begin
      req_pid_i[i*PW +: PW]  = pb + 9'(i);
      req_code_i[i*CW +: CW] = cb + 32'(i);
    end
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [PW+CW-1:0] exp_q[$];
  logic [PW+CW-1:0] exp_word;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(8'h00, 9'h0, 32'h0, 1'b1, 1'b1);

    // Test 1 + 2: single offer, three-way round robin from rr_ptr=0.
    vecs[0]  = mk(8'h08, 9'h002, 32'hDEADBEEC, 1, 1, 0, 9'h000, 32'h0,        8'hFF, 8'h00, 0);
    vecs[1]  = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h005, 32'hDEADBEEF, 8'hFF, 8'h08, 0);
    vecs[2]  = mk(8'h80, 9'h0F0, 32'h77770000, 1, 1, 0, 9'h000, 32'h0,        8'hFF, 8'h00, 1);
    vecs[3]  = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h0F7, 32'h77770007, 8'hFF, 8'h80, 1);
    vecs[4]  = mk(8'h85, 9'h100, 32'h10000000, 1, 1, 0, 9'h000, 32'h0,        8'hFF, 8'h00, 2);
    vecs[5]  = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h100, 32'h10000000, 8'h7B, 8'h85, 2);
    vecs[6]  = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h102, 32'h10000002, 8'h7F, 8'h84, 3);
    vecs[7]  = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h107, 32'h10000007, 8'hFF, 8'h80, 4);
    // Test 3: all eight held, ready toggling; offers while full must be refused.
    vecs[8]  = mk(8'hFF, 9'h080, 32'hA0000000, 1, 1, 0, 9'h000, 32'h0,        8'hFF, 8'h00, 5);
    vecs[9]  = mk(8'hFF, 9'h1F0, 32'hBAD00000, 0, 1, 0, 9'h000, 32'h0,        8'h00, 8'hFF, 5);
    vecs[10] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h080, 32'hA0000000, 8'h01, 8'hFF, 5);
    vecs[11] = mk(8'h00, 9'h000, 32'h0,        0, 1, 0, 9'h000, 32'h0,        8'h01, 8'hFE, 6);
    vecs[12] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h081, 32'hA0000001, 8'h03, 8'hFE, 6);
    vecs[13] = mk(8'h00, 9'h000, 32'h0,        0, 1, 0, 9'h000, 32'h0,        8'h03, 8'hFC, 7);
    vecs[14] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h082, 32'hA0000002, 8'h07, 8'hFC, 7);
    vecs[15] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h083, 32'hA0000003, 8'h0F, 8'hF8, 8);
    vecs[16] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h084, 32'hA0000004, 8'h1F, 8'hF0, 9);
    vecs[17] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h085, 32'hA0000005, 8'h3F, 8'hE0, 10);
    vecs[18] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h086, 32'hA0000006, 8'h7F, 8'hC0, 11);
    vecs[19] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h087, 32'hA0000007, 8'hFF, 8'h80, 12);
    // Test 5: arb_en_i low freezes grants but still accepts.
    vecs[20] = mk(8'h0F, 9'h040, 32'h40000000, 1, 0, 0, 9'h000, 32'h0,        8'hFF, 8'h00, 13);
    vecs[21] = mk(8'h00, 9'h000, 32'h0,        1, 0, 0, 9'h000, 32'h0,        8'hF0, 8'h0F, 13);
    vecs[22] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h040, 32'h40000000, 8'hF1, 8'h0F, 13);
    vecs[23] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h041, 32'h40000001, 8'hF3, 8'h0E, 14);
    vecs[24] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h042, 32'h40000002, 8'hF7, 8'h0C, 15);
    vecs[25] = mk(8'h00, 9'h000, 32'h0,        1, 1, 1, 9'h043, 32'h40000003, 8'hFF, 8'h08, 16);

    // Reset state
    #12;
    check("reset_req_ready", 64'(req_ready_o), 64'hFF);
    check("reset_push", 64'(complete_push_o), 64'h0);
    check("reset_data", 64'(return_data_o), 64'h0);
    check("reset_pending", 64'(pending_o), 64'h0);
    check("reset_count", 64'(cmpl_count_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors, one row per cycle
    for (int r = 0; r < 26; r++) begin
      @(negedge clk);
      drive(vecs[r].valid, vecs[r].pid_base, vecs[r].code_base, vecs[r].rdy, vecs[r].en);
      #1;
      check($sformatf("row%0d_push", r), 64'(complete_push_o), 64'(vecs[r].push));
      check($sformatf("row%0d_data", r), 64'(return_data_o),
            vecs[r].push ? 64'({vecs[r].pid, vecs[r].code}) : 64'h0);
      check($sformatf("row%0d_req_ready", r), 64'(req_ready_o), 64'(vecs[r].rr));
      check($sformatf("row%0d_pending", r), 64'(pending_o), 64'(vecs[r].pend));
      check($sformatf("row%0d_count", r), 64'(cmpl_count_o), 64'(vecs[r].cnt));
    end

    // Test 4: engine 1 streams 20 back-to-back completions.
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      drive((k < 20) ? 8'h02 : 8'h00, 9'h1A9, 32'h50000000 + 32'(k) - 32'd1, 1'b1, 1'b1);
      if (k < 20) exp_q.push_back({9'h1AA, 32'h50000000 + 32'(k)});
      #1;
      if (k == 0) begin
        check("stream_first_no_push", 64'(complete_push_o), 64'h0);
      end else begin
        exp_word = exp_q.pop_front();
        check($sformatf("stream%0d_push", k), 64'(complete_push_o), 64'h1);
        check($sformatf("stream%0d_data", k), 64'(return_data_o), 64'(exp_word));
      end
      check($sformatf("stream%0d_ready1", k), 64'(req_ready_o[1]), 64'h1);
    end
    @(negedge clk);
    drive(8'h00, 9'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check("stream_count", 64'(cmpl_count_o), 64'd37);
    check("stream_drained", 64'(pending_o), 64'h0);

    // Test 6a: push counter wraps from 0xFFFF_FFFF to 0.
    force dut.cmpl_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cmpl_cnt;
    @(negedge clk);
    drive(8'h07, 9'h010, 32'hC0000000, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive(8'h00, 9'h0, 32'h0, 1'b1, 1'b1);
      #1;
      check($sformatf("wrap%0d_push", j), 64'(complete_push_o), 64'h1);
      @(posedge clk);
      #1;
      check($sformatf("wrap%0d_count", j), 64'(cmpl_count_o),
            (j == 0) ? 64'hFFFF_FFFF : ((j == 1) ? 64'h0 : 64'h1));
    end

    // Test 6b: reset with three entries held discards them without a push.
    @(negedge clk);
    drive(8'h70, 9'h020, 32'hE0000000, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h00, 9'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check("prereset_pending", 64'(pending_o), 64'h70);
    rst_n = 1'b0;
    #1;
    check("midreset_pending", 64'(pending_o), 64'h0);
    check("midreset_push", 64'(complete_push_o), 64'h0);
    check("midreset_count", 64'(cmpl_count_o), 64'h0);
    check("midreset_req_ready", 64'(req_ready_o), 64'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00, 9'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check("postreset_push", 64'(complete_push_o), 64'h0);
    check("postreset_pending", 64'(pending_o), 64'h0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
